// File: rtl/regfile_writeback_arbiter_pkg.sv
// regfile_writeback_arbiter_pkg: shared widths and the queued write-back entry type
package regfile_writeback_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_arbiter_wb_load_queue.sv
// wb_load_queue: in-order FIFO of returned load results awaiting the write port
module wb_load_queue
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t din_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU and load results onto the register file write port
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       wr_data
);
    logic                  alu_sel, push, pop, full, empty;
    wb_entry_t             head, ld_entry;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  wr_en_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       wr_data_q;
    assign alu_sel  = alu_valid & (alu_rd != X0);
    assign ld_ready = ~full;
    assign push     = ld_valid & ld_ready & (ld_rd != X0);
    assign pop      = ~alu_sel & ~empty;
    assign ld_entry = '{rd: ld_rd, data: ld_data};
    wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (ld_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    // Issue is applied after the drain clear so a same-cycle set wins
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[head.rd] = 1'b0;
        if (ld_issue) busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_q      <= '0;
            wr_data_q <= '0;
        end else begin
            busy_q  <= busy_d;
            wr_en_q <= alu_sel | pop;
            if (alu_sel) begin
                rd_q      <= alu_rd;
                wr_data_q <= alu_data;
            end else if (pop) begin
                rd_q      <= head.rd;
                wr_data_q <= head.data;
            end
        end
    end
    assign wr_en      = wr_en_q;
    assign rd         = rd_q;
    assign wr_data    = wr_data_q;
    assign hazard_rs1 = (rs1 != X0) & (busy_q[rs1] | (wr_en_q & (rd_q == rs1)));
    assign hazard_rs2 = (rs2 != X0) & (busy_q[rs2] | (wr_en_q & (rd_q == rs2)));
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed vectors with hand-computed write-port expectations
module tb_regfile_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_issue, ld_valid, ld_ready;
    logic [4:0]  alu_rd, ld_issue_rd, ld_rd, rs1, rs2, rd;
    logic [31:0] alu_data, ld_data, wr_data;
    logic        hazard_rs1, hazard_rs2, wr_en;
    int          checks = 0;
    int          passed = 0;
    logic [31:0] outstanding, outstanding_nxt;
    logic        acc;
    int          li, n;
    logic [4:0]  got_rd [8];
    logic [31:0] got_data [8];

    always #5 clk = ~clk;

    regfile_writeback_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1(rs1), .rs2(rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .wr_en(wr_en), .rd(rd), .wr_data(wr_data)
    );

    // Issuer contract: never a second outstanding load to the same register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) outstanding <= '0;
        else begin
            outstanding_nxt = outstanding;
            if (ld_valid && ld_ready) outstanding_nxt[ld_rd] = 1'b0;
            if (ld_issue && ld_issue_rd != 0) begin
                assert (!outstanding[ld_issue_rd])
                else $error("FAIL issue_outstanding rd=%0d", ld_issue_rd);
                outstanding_nxt[ld_issue_rd] = 1'b1;
            end
            outstanding <= outstanding_nxt;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {alu_valid, ld_issue, ld_valid} = '0;
        {alu_rd, ld_issue_rd, ld_rd, rs1, rs2} = '0;
        alu_data = '0;
        ld_data = '0;
        repeat (2) tick();
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd", 32'(rd), 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_hazard_rs1", 32'(hazard_rs1), 0);
        rst_n = 1'b1;
        tick();
        check("rst_ld_ready", 32'(ld_ready), 1);

        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        tick();
        alu_valid = 0;
        check("alu_wr_en", 32'(wr_en), 1);
        check("alu_rd", 32'(rd), 5);
        check("alu_wr_data", wr_data, 32'h1234);
        tick();
        check("alu_idle_wr_en", 32'(wr_en), 0);
        check("alu_idle_rd_hold", 32'(rd), 5);

        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
        ld_valid = 1; ld_rd = 0; ld_data = 32'hFFFF_FFFF;
        tick();
        alu_valid = 0; ld_valid = 0;
        check("x0_wr_en", 32'(wr_en), 0);
        check("x0_ld_ready", 32'(ld_ready), 1);
        tick();
        check("x0_no_drain", 32'(wr_en), 0);
        check("x0_data_hold", wr_data, 32'h1234);

        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
        tick();
        alu_valid = 0; ld_valid = 0;
        check("col_first_rd", 32'(rd), 3);
        check("col_first_data", wr_data, 32'h33);
        tick();
        check("col_second_en", 32'(wr_en), 1);
        check("col_second_rd", 32'(rd), 7);
        check("col_second_data", wr_data, 32'h77);
        tick();
        check("col_done", 32'(wr_en), 0);

        li = 0; n = 0;
        for (int c = 0; c < 12; c++) begin
            alu_valid = c < 4; alu_rd = 5'(10 + c); alu_data = 32'hA0 + 32'(c);
            ld_valid = li < 3; ld_rd = 5'(20 + li); ld_data = 32'hB0 + 32'(li);
            if (c == 2) check("bp_ready_full", 32'(ld_ready), 0);
            if (c == 4) check("bp_ready_still_full", 32'(ld_ready), 0);
            if (c == 5) check("bp_ready_back", 32'(ld_ready), 1);
            acc = ld_valid && ld_ready;
            tick();
            if (acc) li++;
            if (wr_en && n < 8) begin
                got_rd[n] = rd; got_data[n] = wr_data; n++;
            end
        end
        alu_valid = 0; ld_valid = 0;
        check("bp_write_count", 32'(n), 7);
        for (int i = 0; i < 4; i++) begin
            check("bp_alu_rd", 32'(got_rd[i]), 32'(10 + i));
            check("bp_alu_data", got_data[i], 32'hA0 + 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_ld_rd", 32'(got_rd[4 + i]), 32'(20 + i));
            check("bp_ld_data", got_data[4 + i], 32'hB0 + 32'(i));
        end

        ld_issue = 1; ld_issue_rd = 9; rs1 = 9; rs2 = 0;
        tick();
        ld_issue = 0;
        check("sb_hazard_set", 32'(hazard_rs1), 1);
        check("sb_rs2_x0", 32'(hazard_rs2), 0);
        rs1 = 0;
        #1;
        check("sb_rs1_x0", 32'(hazard_rs1), 0);
        rs1 = 9;
        repeat (2) tick();
        check("sb_hazard_wait", 32'(hazard_rs1), 1);
        ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
        tick();
        ld_valid = 0;
        check("sb_hazard_queued", 32'(hazard_rs1), 1);
        tick();
        check("sb_write_rd", 32'(rd), 9);
        check("sb_write_data", wr_data, 32'h99);
        check("sb_hazard_on_port", 32'(hazard_rs1), 1);
        tick();
        check("sb_hazard_clear", 32'(hazard_rs1), 0);

        ld_issue = 1; ld_issue_rd = 12; rs2 = 12;
        tick();
        ld_issue = 0;
        alu_valid = 1; alu_rd = 12; alu_data = 32'hC;
        tick();
        alu_valid = 0;
        check("waw_alu_write", 32'(wr_en && rd == 12), 1);
        tick();
        check("waw_busy_kept", 32'(hazard_rs2), 1);

        ld_issue = 1; ld_issue_rd = 25; rs1 = 25;
        tick();
        ld_issue = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        ld_valid = 1; ld_rd = 25; ld_data = 32'h25;
        tick();
        ld_rd = 26; ld_data = 32'h26;
        tick();
        ld_valid = 0; alu_valid = 0;
        check("mr_queue_full", 32'(ld_ready), 0);
        check("mr_hazard_before", 32'(hazard_rs1), 1);
        rst_n = 1'b0;
        #2;
        check("mr_wr_en", 32'(wr_en), 0);
        check("mr_ld_ready", 32'(ld_ready), 1);
        check("mr_hazard_rs1", 32'(hazard_rs1), 0);
        check("mr_hazard_rs2", 32'(hazard_rs2), 0);
        rst_n = 1'b1;
        tick();
        check("mr_no_drain", 32'(wr_en), 0);
        tick();
        check("mr_no_drain2", 32'(wr_en), 0);
        check("mr_ready_after", 32'(ld_ready), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
